// File: rtl/dh_keyex_pkg.sv
// dh_keyex_pkg: shared types and constants for the key-exchange controller.
// Holds the state/display codes, scancode map and exponentiator latency.
package dh_keyex_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_EDIT_G = 4'd1,
      ST_EDIT_P = 4'd2,
      ST_EDIT_X = 4'd3,
      ST_EDIT_Y = 4'd4,
      ST_CALC   = 4'd5,
      ST_DONE   = 4'd6,
      ST_ERR    = 4'd7
   } st_t;

   typedef enum logic [1:0] {
      M_IDLE = 2'd0,
      M_RUN  = 2'd1,
      M_FIN  = 2'd2
   } mx_st_t;

   typedef struct packed {
      logic       v;
      logic [3:0] d;
   } dig_t;

   localparam logic [7:0] SC_D0   = 8'h45;
   localparam logic [7:0] SC_D1   = 8'h16;
   localparam logic [7:0] SC_D2   = 8'h1E;
   localparam logic [7:0] SC_D3   = 8'h26;
   localparam logic [7:0] SC_D4   = 8'h25;
   localparam logic [7:0] SC_D5   = 8'h2E;
   localparam logic [7:0] SC_D6   = 8'h36;
   localparam logic [7:0] SC_D7   = 8'h3D;
   localparam logic [7:0] SC_D8   = 8'h3E;
   localparam logic [7:0] SC_D9   = 8'h46;
   localparam logic [7:0] SC_G    = 8'h34;
   localparam logic [7:0] SC_P    = 8'h4D;
   localparam logic [7:0] SC_X    = 8'h22;
   localparam logic [7:0] SC_Y    = 8'h35;
   localparam logic [7:0] SC_ENT  = 8'h5A;
   localparam logic [7:0] SC_BKSP = 8'h66;
   localparam logic [7:0] SC_ESC  = 8'h76;
   localparam logic [7:0] SC_BRK  = 8'hF0;
   localparam logic [7:0] SC_EXT  = 8'hE0;

   function automatic int LAT_EXP(input int w);
      return 2 * w * (w + 1) + 2;
   endfunction

   function automatic dig_t sc_digit(input logic [7:0] c);
      dig_t r;
      r.v = 1'b1;
      r.d = 4'd0;
      case (c)
         SC_D0:   r.d = 4'd0;
         SC_D1:   r.d = 4'd1;
         SC_D2:   r.d = 4'd2;
         SC_D3:   r.d = 4'd3;
         SC_D4:   r.d = 4'd4;
         SC_D5:   r.d = 4'd5;
         SC_D6:   r.d = 4'd6;
         SC_D7:   r.d = 4'd7;
         SC_D8:   r.d = 4'd8;
         SC_D9:   r.d = 4'd9;
         default: r.v = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dh_keyex_ctrl_if.sv
// dh_keyex_ctrl_if: scancode byte stream from the PS/2 receiver.
// SCAN is the byte, SCAN_VLD a one-cycle strobe; master drives, slave samples.
interface dh_keyex_ctrl_if #(
   parameter int SCAN_W = 8
);
   logic [SCAN_W-1:0] SCAN;
   logic              SCAN_VLD;

   modport master (output SCAN, output SCAN_VLD);
   modport slave  (input  SCAN, input  SCAN_VLD);
endinterface

// File: rtl/dh_keyex_ctrl_modexp.sv
// dh_modexp: constant-time left-to-right modular exponentiation.
// Ports: CLK, RST_N, start, abort, base/exp/mod in; busy, done pulse, result out.
module dh_modexp
   import dh_keyex_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         start,
   input  logic         abort,
   input  logic [W-1:0] base,
   input  logic [W-1:0] exp,
   input  logic [W-1:0] mod,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result
);

   localparam int CW = $clog2(W + 1);
   localparam logic [CW-1:0] CLAST = CW'(W);
   localparam logic [CW-1:0] NLAST = CW'(W - 1);

   mx_st_t        st;
   logic          mul;
   logic [CW-1:0] cnt;
   logic [CW-1:0] nb;
   logic [W-1:0]  bse, ex, md, r, ma, mb;
   logic [W+1:0]  acc, mp, t0, t1, t2;

   // One shift-add step: acc < p keeps 2*acc + a below 3p,
   // so two conditional subtracts bring it back under p.
   assign mp   = {2'b00, md};
   assign t0   = {acc[W:0], 1'b0} + (mb[W-1] ? {2'b00, ma} : '0);
   assign t1   = (t0 >= mp) ? t0 - mp : t0;
   assign t2   = (t1 >= mp) ? t1 - mp : t1;
   assign busy = (st != M_IDLE);

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         st     <= M_IDLE;
         mul    <= 1'b0;
         cnt    <= '0;
         nb     <= '0;
         bse    <= '0;
         ex     <= '0;
         md     <= '0;
         r      <= '0;
         ma     <= '0;
         mb     <= '0;
         acc    <= '0;
         done   <= 1'b0;
         result <= '0;
      end else if (abort) begin
         st   <= M_IDLE;
         mul  <= 1'b0;
         cnt  <= '0;
         nb   <= '0;
         acc  <= '0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (st)
            M_IDLE: if (start) begin
               bse <= base;
               ex  <= exp;
               md  <= mod;
               r   <= (mod == W'(1)) ? '0 : W'(1);
               mul <= 1'b0;
               cnt <= '0;
               nb  <= '0;
               st  <= M_RUN;
            end
            M_RUN: begin
               if (cnt == '0) begin
                  acc <= '0;
                  ma  <= r;
                  mb  <= mul ? bse : r;
                  cnt <= cnt + CW'(1);
               end else begin
                  acc <= t2;
                  mb  <= mb << 1;
                  if (cnt == CLAST) begin
                     cnt <= '0;
                     mul <= ~mul;
                     if (!mul) begin
                        r <= t2[W-1:0];
                     end else begin
                        // multiply always runs; keep it only for a 1 bit
                        if (ex[W-1]) r <= t2[W-1:0];
                        ex <= ex << 1;
                        if (nb == NLAST) st <= M_FIN;
                        else             nb <= nb + CW'(1);
                     end
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            M_FIN: begin
               result <= r;
               done   <= 1'b1;
               st     <= M_IDLE;
            end
            default: st <= M_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/dh_keyex_ctrl.sv
// dh_keyex_ctrl: scancode filter, operand entry FSM and DH result registers.
// Ports: CLK, RST_N, ps2 (SCAN/SCAN_VLD), KEY_OUT, STATE_OUT, BUSY, DONE, ERR, A_PUB, B_PUB, SHARED.
module dh_keyex_ctrl
   import dh_keyex_pkg::*;
#(
   parameter int W      = 8,
   parameter int SCAN_W = 8
) (
   input  logic           CLK,
   input  logic           RST_N,
   dh_keyex_ctrl_if.slave ps2,
   output logic [W-1:0]   KEY_OUT,
   output logic [3:0]     STATE_OUT,
   output logic           BUSY,
   output logic           DONE,
   output logic           ERR,
   output logic [W-1:0]   A_PUB,
   output logic [W-1:0]   B_PUB,
   output logic [W-1:0]   SHARED
);

   logic         brk, ext, kv;
   logic [7:0]   kc;
   dig_t         dg;
   logic         k_g, k_p, k_x, k_y, k_ent, k_bks, k_esc, k_sel, is_dig;
   st_t          state;
   logic [W-1:0] g, p, x, y, cur, fnew, sel_val;
   st_t          sel_st;
   logic [2*W-1:0] app;
   logic         ovf, fwe, bad;
   logic [1:0]   ph;
   logic         start_r, abort;
   logic         mx_start, mx_busy, mx_done;
   logic [W-1:0] mx_base, mx_exp, mx_res;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         brk <= 1'b0;
         ext <= 1'b0;
         kv  <= 1'b0;
         kc  <= '0;
      end else begin
         kv <= 1'b0;
         if (ps2.SCAN_VLD) begin
            if (ps2.SCAN == SCAN_W'(SC_BRK)) begin
               brk <= 1'b1;
            end else if (ps2.SCAN == SCAN_W'(SC_EXT)) begin
               ext <= 1'b1;
            end else if (brk || ext) begin
               brk <= 1'b0;
               ext <= 1'b0;
            end else begin
               kv <= 1'b1;
               kc <= 8'(ps2.SCAN);
            end
         end
      end
   end

   assign dg     = sc_digit(kc);
   assign is_dig = kv && dg.v;
   assign k_g    = kv && (kc == SC_G);
   assign k_p    = kv && (kc == SC_P);
   assign k_x    = kv && (kc == SC_X);
   assign k_y    = kv && (kc == SC_Y);
   assign k_ent  = kv && (kc == SC_ENT);
   assign k_bks  = kv && (kc == SC_BKSP);
   assign k_esc  = kv && (kc == SC_ESC);
   assign k_sel  = k_g || k_p || k_x || k_y;

   always_comb begin
      cur = '0;
      unique case (state)
         ST_EDIT_G: cur = g;
         ST_EDIT_P: cur = p;
         ST_EDIT_X: cur = x;
         ST_EDIT_Y: cur = y;
         default:   cur = '0;
      endcase
   end

   always_comb begin
      sel_st  = ST_EDIT_G;
      sel_val = g;
      unique case (1'b1)
         k_p: begin sel_st = ST_EDIT_P; sel_val = p; end
         k_x: begin sel_st = ST_EDIT_X; sel_val = x; end
         k_y: begin sel_st = ST_EDIT_Y; sel_val = y; end
         default: ;
      endcase
   end

   // Append at double width so an overflowing digit can be rejected.
   assign app  = (2*W)'(cur) * (2*W)'(10) + (2*W)'(dg.d);
   assign ovf  = |app[2*W-1:W];
   assign fwe  = (is_dig && !ovf) || k_bks;
   assign fnew = k_bks ? cur / W'(10) : app[W-1:0];
   assign bad  = (p < W'(2)) || (g == '0) || (g >= p);

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state   <= ST_IDLE;
         g       <= '0;
         p       <= '0;
         x       <= '0;
         y       <= '0;
         A_PUB   <= '0;
         B_PUB   <= '0;
         SHARED  <= '0;
         KEY_OUT <= '0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
         ERR     <= 1'b0;
         ph      <= 2'd0;
         start_r <= 1'b0;
      end else begin
         start_r <= 1'b0;
         if (k_esc) begin
            state   <= ST_IDLE;
            g       <= '0;
            p       <= '0;
            x       <= '0;
            y       <= '0;
            KEY_OUT <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            ERR     <= 1'b0;
            ph      <= 2'd0;
            if (state == ST_CALC) begin
               A_PUB  <= '0;
               B_PUB  <= '0;
               SHARED <= '0;
            end
         end else begin
            unique case (state)
               ST_IDLE: if (k_sel) begin
                  state   <= sel_st;
                  KEY_OUT <= sel_val;
               end
               ST_EDIT_G, ST_EDIT_P, ST_EDIT_X, ST_EDIT_Y: begin
                  unique case (1'b1)
                     k_sel: begin
                        state   <= sel_st;
                        KEY_OUT <= sel_val;
                     end
                     k_ent: begin
                        KEY_OUT <= '0;
                        if (bad) begin
                           state <= ST_ERR;
                           ERR   <= 1'b1;
                        end else begin
                           state   <= ST_CALC;
                           BUSY    <= 1'b1;
                           ph      <= 2'd0;
                           start_r <= 1'b1;
                        end
                     end
                     fwe: begin
                        KEY_OUT <= fnew;
                        case (state)
                           ST_EDIT_G: g <= fnew;
                           ST_EDIT_P: p <= fnew;
                           ST_EDIT_X: x <= fnew;
                           ST_EDIT_Y: y <= fnew;
                           default: ;
                        endcase
                     end
                     default: ;
                  endcase
               end
               ST_CALC: if (mx_done) begin
                  case (ph)
                     2'd0: begin
                        A_PUB   <= mx_res;
                        ph      <= 2'd1;
                        start_r <= 1'b1;
                     end
                     2'd1: begin
                        B_PUB   <= mx_res;
                        ph      <= 2'd2;
                        start_r <= 1'b1;
                     end
                     default: begin
                        SHARED  <= mx_res;
                        KEY_OUT <= mx_res;
                        state   <= ST_DONE;
                        BUSY    <= 1'b0;
                        DONE    <= 1'b1;
                     end
                  endcase
               end
               ST_DONE: begin
                  unique case (1'b1)
                     k_g, k_p: begin
                        state   <= sel_st;
                        KEY_OUT <= sel_val;
                        DONE    <= 1'b0;
                     end
                     k_x:   KEY_OUT <= A_PUB;
                     k_y:   KEY_OUT <= B_PUB;
                     k_ent: KEY_OUT <= SHARED;
                     default: ;
                  endcase
               end
               ST_ERR: if (k_sel) begin
                  state   <= sel_st;
                  KEY_OUT <= sel_val;
                  ERR     <= 1'b0;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign STATE_OUT = state;
   assign abort     = k_esc && (state == ST_CALC);
   assign mx_start  = start_r && !abort && !mx_busy;
   // S reuses the freshly registered A as its base; A and B share g.
   assign mx_base   = (ph == 2'd2) ? A_PUB : g;
   assign mx_exp    = (ph == 2'd0) ? x : y;

   dh_modexp #(.W(W)) u_modexp (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .start  (mx_start),
      .abort  (abort),
      .base   (mx_base),
      .exp    (mx_exp),
      .mod    (p),
      .busy   (mx_busy),
      .done   (mx_done),
      .result (mx_res)
   );

endmodule

// File: tb/tb_dh_keyex_ctrl.sv
// tb_dh_keyex_ctrl: directed plan items plus randomized exchanges
// against a key-level behavioural model of the controller.
module tb_dh_keyex_ctrl;

   localparam int W        = 8;
   localparam int LAT      = 2 * W * (W + 1) + 2;
   localparam int CALC_CYC = 3 * (LAT + 1);

   localparam logic [7:0] K_G   = 8'h34;
   localparam logic [7:0] K_P   = 8'h4D;
   localparam logic [7:0] K_X   = 8'h22;
   localparam logic [7:0] K_Y   = 8'h35;
   localparam logic [7:0] K_ENT = 8'h5A;
   localparam logic [7:0] K_BKS = 8'h66;
   localparam logic [7:0] K_ESC = 8'h76;
   localparam logic [7:0] K_BRK = 8'hF0;
   localparam logic [7:0] K_EXT = 8'hE0;

   logic [7:0] dig_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                               8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

   logic         CLK = 1'b0;
   logic         RST_N = 1'b0;
   logic [W-1:0] KEY_OUT, A_PUB, B_PUB, SHARED;
   logic [3:0]   STATE_OUT;
   logic         BUSY, DONE, ERR;

   int checks = 0;
   int errors = 0;

   int mst, mkey, ma, mb, ms;
   int f [4];

   dh_keyex_ctrl_if #(.SCAN_W(8)) ps2 ();

   dh_keyex_ctrl #(.W(W), .SCAN_W(8)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .ps2       (ps2),
      .KEY_OUT   (KEY_OUT),
      .STATE_OUT (STATE_OUT),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .ERR       (ERR),
      .A_PUB     (A_PUB),
      .B_PUB     (B_PUB),
      .SHARED    (SHARED)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input int exp);
      checks++;
      if (got !== 32'(exp)) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int modpow(input int b, input int e, input int m);
      longint r;
      r = 1 % m;
      for (int i = 0; i < e; i++) r = (r * b) % m;
      return int'(r);
   endfunction

   // 0-9 digit, 10..13 G/P/X/Y, 14 ENTER, 15 BKSP, 16 ESC, -1 other
   function automatic int dec(input logic [7:0] c);
      for (int i = 0; i < 10; i++) if (dig_sc[i] == c) return i;
      case (c)
         K_G:     return 10;
         K_P:     return 11;
         K_X:     return 12;
         K_Y:     return 13;
         K_ENT:   return 14;
         K_BKS:   return 15;
         K_ESC:   return 16;
         default: return -1;
      endcase
   endfunction

   task automatic mdl_reset();
      mst = 0; mkey = 0; ma = 0; mb = 0; ms = 0;
      for (int i = 0; i < 4; i++) f[i] = 0;
   endtask

   task automatic mdl_key(input logic [7:0] c);
      int e;
      int i;
      e = dec(c);
      if (e < 0) return;
      if (e == 16) begin
         if (mst == 5) begin ma = 0; mb = 0; ms = 0; end
         for (int k = 0; k < 4; k++) f[k] = 0;
         mst = 0; mkey = 0;
         return;
      end
      case (mst)
         0, 7: if (e >= 10 && e <= 13) begin mst = e - 9; mkey = f[e-10]; end
         1, 2, 3, 4: begin
            i = mst - 1;
            if (e <= 9) begin
               if (f[i] * 10 + e < (1 << W)) f[i] = f[i] * 10 + e;
               mkey = f[i];
            end else if (e == 15) begin
               f[i] = f[i] / 10; mkey = f[i];
            end else if (e <= 13) begin
               mst = e - 9; mkey = f[e-10];
            end else if (e == 14) begin
               if (f[1] < 2 || f[0] == 0 || f[0] >= f[1]) mst = 7;
               else mst = 5;
               mkey = 0;
            end
         end
         6: begin
            if (e == 12) mkey = ma;
            else if (e == 13) mkey = mb;
            else if (e == 14) mkey = ms;
            else if (e == 10 || e == 11) begin mst = e - 9; mkey = f[e-10]; end
         end
         default: ;
      endcase
   endtask

   task automatic cmp_all(input string tag);
      chk({tag, ".st"}, 32'(STATE_OUT), mst);
      if (mst != 5) chk({tag, ".key"}, 32'(KEY_OUT), mkey);
      chk({tag, ".busy"}, 32'(BUSY), int'(mst == 5));
      chk({tag, ".done"}, 32'(DONE), int'(mst == 6));
      chk({tag, ".err"}, 32'(ERR), int'(mst == 7));
      chk({tag, ".a"}, 32'(A_PUB), ma);
      chk({tag, ".b"}, 32'(B_PUB), mb);
      chk({tag, ".s"}, 32'(SHARED), ms);
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge CLK);
      ps2.SCAN = b;
      ps2.SCAN_VLD = 1'b1;
      @(negedge CLK);
      ps2.SCAN_VLD = 1'b0;
      @(negedge CLK);
   endtask

   task automatic key(input logic [7:0] c, input string tag);
      send(c);
      mdl_key(c);
      cmp_all(tag);
   endtask

   task automatic send_pre(input logic [7:0] pre, input logic [7:0] c, input string tag);
      send(pre);
      send(c);
      cmp_all(tag);
   endtask

   task automatic run_calc();
      int n;
      n = 0;
      while (BUSY === 1'b1 && n < CALC_CYC + 20) begin
         n++;
         @(negedge CLK);
      end
      chk("busy_cycles", 32'(n), CALC_CYC);
      ma = modpow(f[0], f[2], f[1]);
      mb = modpow(f[0], f[3], f[1]);
      ms = modpow(ma, f[3], f[1]);
      mst = 6;
      mkey = ms;
      cmp_all("calc");
   endtask

   task automatic enter();
      key(K_ENT, "ent");
      if (mst == 5) run_calc();
   endtask

   task automatic type_num(input int v);
      if (v >= 100) key(dig_sc[(v / 100) % 10], "d100");
      if (v >= 10)  key(dig_sc[(v / 10) % 10], "d10");
      key(dig_sc[v % 10], "d1");
   endtask

   task automatic set_field(input logic [7:0] s, input int v);
      key(s, "sel");
      repeat (3) key(K_BKS, "clr");
      type_num(v);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pv, gv, xv, yv, r0;
      logic [7:0] junk;
      ps2.SCAN = '0;
      ps2.SCAN_VLD = 1'b0;
      mdl_reset();
      RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      cmp_all("reset");
      RST_N = 1'b1;

      // textbook exchange
      key(K_G, "g"); key(dig_sc[5], "g5");
      key(K_P, "p"); key(dig_sc[2], "p2"); key(dig_sc[3], "p3");
      key(K_X, "x"); key(dig_sc[6], "x6");
      key(K_Y, "y"); key(dig_sc[1], "y1"); key(dig_sc[5], "y5");
      enter();
      chk("tb_a", 32'(A_PUB), 8);
      chk("tb_b", 32'(B_PUB), 19);
      chk("tb_s", 32'(SHARED), 2);
      chk("tb_st", 32'(STATE_OUT), 6);
      key(K_X, "tb_showx");
      chk("tb_keyx", 32'(KEY_OUT), 8);
      key(K_Y, "tb_showy");
      chk("tb_keyy", 32'(KEY_OUT), 19);

      // break / extend filtering
      key(K_ESC, "esc");
      key(K_G, "brk_g");
      key(dig_sc[1], "brk_1");
      send_pre(K_BRK, dig_sc[1], "brk_rel");
      chk("brk_key", 32'(KEY_OUT), 1);
      send_pre(K_EXT, K_ENT, "ext_ent");
      chk("ext_busy", 32'(BUSY), 0);
      chk("ext_st", 32'(STATE_OUT), 1);

      // overflow and backspace
      key(K_BKS, "ov_clr");
      key(dig_sc[2], "ov2"); key(dig_sc[5], "ov5"); key(dig_sc[5], "ov5b");
      chk("ov_255", 32'(KEY_OUT), 255);
      key(dig_sc[9], "ov9");
      chk("ov_hold", 32'(KEY_OUT), 255);
      key(K_BKS, "ov_bks");
      chk("ov_25", 32'(KEY_OUT), 25);
      key(dig_sc[6], "ov6");
      chk("ov_256", 32'(KEY_OUT), 25);

      // validation
      set_field(K_P, 1);
      key(K_ENT, "v_p1");
      chk("v_p1_err", 32'(ERR), 1);
      chk("v_p1_st", 32'(STATE_OUT), 7);
      key(K_P, "v_back");
      chk("v_back_st", 32'(STATE_OUT), 2);
      chk("v_back_key", 32'(KEY_OUT), 1);
      set_field(K_G, 23);
      set_field(K_P, 23);
      key(K_ENT, "v_geq");
      chk("v_geq_err", 32'(ERR), 1);

      // escape during compute
      key(K_G, "e_g");
      set_field(K_G, 5); set_field(K_P, 23);
      set_field(K_X, 6); set_field(K_Y, 15);
      key(K_ENT, "e_ent");
      repeat (40) @(negedge CLK);
      key(K_ESC, "e_esc");
      chk("e_st", 32'(STATE_OUT), 0);
      chk("e_a", 32'(A_PUB), 0);
      key(K_X, "e_x");
      key(dig_sc[7], "e_x7");
      chk("e_x7v", 32'(KEY_OUT), 7);

      // reset mid-compute
      set_field(K_G, 3); set_field(K_P, 17);
      set_field(K_X, 5); set_field(K_Y, 7);
      key(K_ENT, "r_ent");
      repeat (200) @(negedge CLK);
      RST_N = 1'b0;
      @(negedge CLK);
      mdl_reset();
      cmp_all("r_mid");
      RST_N = 1'b1;
      repeat (LAT) @(negedge CLK);
      cmp_all("r_quiet");

      // randomized exchanges
      for (int it = 0; it < 14; it++) begin
         key(K_ESC, "rn_esc");
         pv = $urandom_range(2, 255);
         r0 = $urandom_range(0, 7);
         if (r0 == 0)      gv = 0;
         else if (r0 == 1) gv = $urandom_range(pv, 255);
         else              gv = $urandom_range(1, pv - 1);
         xv = $urandom_range(0, 255);
         yv = $urandom_range(0, 255);
         set_field(K_Y, yv);
         set_field(K_P, pv);
         if ($urandom_range(0, 1) == 1) key(dig_sc[$urandom_range(0, 9)], "rn_extra");
         set_field(K_G, gv);
         send_pre(K_BRK, dig_sc[$urandom_range(0, 9)], "rn_brk");
         set_field(K_X, xv);
         junk = 8'($urandom_range(0, 255));
         if (junk != K_BRK && junk != K_EXT) key(junk, "rn_junk");
         enter();
         if (mst == 6) begin
            key(K_X, "rn_vx");
            key(K_Y, "rn_vy");
            key(dig_sc[3], "rn_vdig");
            key(K_ENT, "rn_vs");
            key(K_P, "rn_back");
         end else if (mst == 7) begin
            key(K_P, "rn_errp");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
